// File: rtl/fwd_pkg.sv
// Shared definitions for the EX-stage forwarding select controller.
package fwd_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned SEL_W      = 2;

  // 3:1 operand mux select codes
  localparam logic [SEL_W-1:0] SEL_REGFILE = 2'd0;
  localparam logic [SEL_W-1:0] SEL_EXMEM   = 2'd1;
  localparam logic [SEL_W-1:0] SEL_MEMWB   = 2'd2;

  // Destination metadata tracked per pipeline stage
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  we;
    logic                  load;
  } stage_entry_t;

  // Younger producer (EX) wins over older (MEM); x0 is never forwarded.
  function automatic logic [SEL_W-1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] rs,
    input stage_entry_t          ex,
    input stage_entry_t          mem
  );
    logic [SEL_W-1:0] sel;
    sel = SEL_REGFILE;
    if (rs == '0) begin
      sel = SEL_REGFILE;
    end else if (ex.valid && ex.we && (ex.rd == rs)) begin
      sel = SEL_EXMEM;
    end else if (mem.valid && mem.we && (mem.rd == rs)) begin
      sel = SEL_MEMWB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/fwd_stage_reg.sv
// Per-stage destination metadata register with hold and bubble insert.
module fwd_stage_reg
  import fwd_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         hold,
  input  logic         bubble,
  input  stage_entry_t entry_in,
  output stage_entry_t entry_out
);

  stage_entry_t entry_d;
  stage_entry_t entry_q;

  // Next entry: hold wins, then bubble (all-zero, so we=0), else load
  always_comb begin
    entry_d = entry_q;
    if (!hold) begin
      entry_d = bubble ? '0 : entry_in;
    end
  end

  // Stage register, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign entry_out = entry_q;

endmodule

// File: rtl/fwd_select_ctrl.sv
// Registered EX operand-mux select generation with load-use hazard detection.
module fwd_select_ctrl #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned SEL_W      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_we,
  input  logic                  id_is_load,
  input  logic                  stall,
  input  logic                  flush,
  output logic [SEL_W-1:0]      ex_rs1_sel,
  output logic [SEL_W-1:0]      ex_rs2_sel,
  output logic                  ex_valid,
  output logic                  hazard_stall
);

  import fwd_pkg::*;

  stage_entry_t     id_entry;
  stage_entry_t     ex_entry;
  stage_entry_t     mem_entry;
  logic             ex_bubble;
  logic             load_use;
  logic [SEL_W-1:0] rs1_sel_d, rs1_sel_q;
  logic [SEL_W-1:0] rs2_sel_d, rs2_sel_q;

  // Decode entry; an invalid slot enters EX as a bubble with we/load cleared
  always_comb begin
    id_entry       = '0;
    id_entry.valid = id_valid;
    id_entry.rd    = id_rd;
    id_entry.we    = id_we & id_valid;
    id_entry.load  = id_is_load & id_valid;
  end

  // Load in EX whose result the decode instruction needs next cycle
  always_comb begin
    load_use = id_valid && ex_entry.valid && ex_entry.load && ex_entry.we &&
               (ex_entry.rd != '0) &&
               ((ex_entry.rd == id_rs1) || (ex_entry.rd == id_rs2));
    hazard_stall = load_use && !rst;
  end

  assign ex_bubble = flush || load_use;

  fwd_stage_reg u_ex_stage (
    .clk       (clk),
    .rst       (rst),
    .hold      (stall),
    .bubble    (ex_bubble),
    .entry_in  (id_entry),
    .entry_out (ex_entry)
  );

  fwd_stage_reg u_mem_stage (
    .clk       (clk),
    .rst       (rst),
    .hold      (stall),
    .bubble    (1'b0),
    .entry_in  (ex_entry),
    .entry_out (mem_entry)
  );

  // Next selects: frozen on stall, zero for bubbles, else forwarding result
  always_comb begin
    rs1_sel_d = rs1_sel_q;
    rs2_sel_d = rs2_sel_q;
    if (!stall) begin
      if (ex_bubble || !id_valid) begin
        rs1_sel_d = SEL_REGFILE;
        rs2_sel_d = SEL_REGFILE;
      end else begin
        rs1_sel_d = fwd_sel(id_rs1, ex_entry, mem_entry);
        rs2_sel_d = fwd_sel(id_rs2, ex_entry, mem_entry);
      end
    end
  end

  // Select output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs1_sel_q <= '0;
      rs2_sel_q <= '0;
    end else begin
      rs1_sel_q <= rs1_sel_d;
      rs2_sel_q <= rs2_sel_d;
    end
  end

  assign ex_rs1_sel = rs1_sel_q;
  assign ex_rs2_sel = rs2_sel_q;
  assign ex_valid   = ex_entry.valid;

endmodule

// File: tb/tb_fwd_select_ctrl.sv
// Directed-vector bench for fwd_select_ctrl.
module tb_fwd_select_ctrl;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic [4:0] id_rd;
  logic       id_we;
  logic       id_is_load;
  logic       stall;
  logic       flush;
  logic [1:0] ex_rs1_sel;
  logic [1:0] ex_rs2_sel;
  logic       ex_valid;
  logic       hazard_stall;

  int total = 0;
  int bad   = 0;

  fwd_select_ctrl #(
    .REG_ADDR_W (5),
    .SEL_W      (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rd        (id_rd),
    .id_we        (id_we),
    .id_is_load   (id_is_load),
    .stall        (stall),
    .flush        (flush),
    .ex_rs1_sel   (ex_rs1_sel),
    .ex_rs2_sel   (ex_rs2_sel),
    .ex_valid     (ex_valid),
    .hazard_stall (hazard_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic we, input logic ld);
    id_valid   = v;
    id_rs1     = rs1;
    id_rs2     = rs2;
    id_rd      = rd;
    id_we      = we;
    id_is_load = ld;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle2;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    step();
    step();
  endtask

  initial begin
    rst   = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    step();
    step();
    chk("rst_sel1", ex_rs1_sel, 0);
    chk("rst_sel2", ex_rs2_sel, 0);
    chk("rst_valid", ex_valid, 0);
    chk("rst_haz", hazard_stall, 0);
    rst = 1'b0;
    step();

    // 1: back-to-back dependency
    drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0); step();
    drive(1'b1, 5'd5, 5'd6, 5'd0, 1'b0, 1'b0); step();
    chk("b2b_sel1", ex_rs1_sel, 1);
    chk("b2b_sel2", ex_rs2_sel, 0);
    chk("b2b_valid", ex_valid, 1);
    idle2();
    chk("idle_valid", ex_valid, 0);

    // 2a: distance-2 and distance-1 on different operands
    drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0); step();
    drive(1'b1, 5'd0, 5'd0, 5'd8, 1'b1, 1'b0); step();
    drive(1'b1, 5'd7, 5'd8, 5'd0, 1'b0, 1'b0); step();
    chk("d2_sel1", ex_rs1_sel, 2);
    chk("d2_sel2", ex_rs2_sel, 1);
    idle2();

    // 2b: younger producer wins
    drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0); step();
    drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0); step();
    drive(1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0); step();
    chk("young_sel1", ex_rs1_sel, 1);
    chk("young_sel2", ex_rs2_sel, 0);
    idle2();

    // 3: load-use
    drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1); step();
    drive(1'b1, 5'd0, 5'd3, 5'd0, 1'b0, 1'b0); #1;
    chk("lu_haz_on", hazard_stall, 1);
    step();
    chk("lu_bub_valid", ex_valid, 0);
    chk("lu_bub_sel1", ex_rs1_sel, 0);
    chk("lu_bub_sel2", ex_rs2_sel, 0);
    chk("lu_haz_off", hazard_stall, 0);
    step();
    chk("lu_retry_sel2", ex_rs2_sel, 2);
    chk("lu_retry_sel1", ex_rs1_sel, 0);
    chk("lu_retry_valid", ex_valid, 1);
    idle2();

    // load to x0 never stalls
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1); step();
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); #1;
    chk("lu_x0_haz", hazard_stall, 0);
    idle2();

    // load-use only when decode slot is valid
    drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1); step();
    drive(1'b0, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0); #1;
    chk("lu_idv0_haz", hazard_stall, 0);
    idle2();

    // 4: x0 and non-writers
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0); step();
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); step();
    chk("x0_sel1", ex_rs1_sel, 0);
    idle2();
    drive(1'b1, 5'd0, 5'd0, 5'd4, 1'b0, 1'b0); step();
    drive(1'b1, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0); step();
    chk("nowe_sel1", ex_rs1_sel, 0);
    idle2();

    // 5: stall with flush held, then flush alone
    drive(1'b1, 5'd0, 5'd0, 5'd2, 1'b1, 1'b0); step();
    drive(1'b1, 5'd2, 5'd0, 5'd9, 1'b1, 1'b0); step();
    chk("sf_pre_sel1", ex_rs1_sel, 1);
    drive(1'b1, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0);
    stall = 1'b1;
    flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("sf_hold_sel1", ex_rs1_sel, 1);
      chk("sf_hold_sel2", ex_rs2_sel, 0);
      chk("sf_hold_valid", ex_valid, 1);
      chk("sf_hold_haz", hazard_stall, 0);
    end
    stall = 1'b0;
    step();
    chk("sf_flush_valid", ex_valid, 0);
    chk("sf_flush_sel1", ex_rs1_sel, 0);
    chk("sf_flush_sel2", ex_rs2_sel, 0);
    flush = 1'b0;
    step();
    chk("sf_mem_sel1", ex_rs1_sel, 2);
    chk("sf_mem_valid", ex_valid, 1);
    idle2();

    // 6: asynchronous reset mid-cycle
    drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0); step();
    drive(1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0); step();
    chk("ar_pre_sel1", ex_rs1_sel, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_sel1", ex_rs1_sel, 0);
    chk("ar_sel2", ex_rs2_sel, 0);
    chk("ar_valid", ex_valid, 0);
    chk("ar_haz", hazard_stall, 0);
    step();
    rst = 1'b0;
    drive(1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0); step();
    chk("ar_post_sel1", ex_rs1_sel, 0);
    chk("ar_post_valid", ex_valid, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fwd_select_ctrl.md
Name: fwd_select_ctrl

Overview:
Produces the registered 2-bit select codes that drive the EX-stage 3:1 operand muxes (s0 = regfile, s1 = EX/MEM result, s2 = MEM/WB result).
- Tracks destination-register metadata for the instructions in the EX and MEM stages.
- Detects load-use hazards.
- Honours external stall and flush.
- Sits beside the decode stage; its outputs are consumed one cycle later by the EX-stage muxes.

Parameters:
REG_ADDR_W, 5, register address width
SEL_W, 2, select code width (matches the 3:1 mux sel)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
id_valid  in  1  decode stage holds a real instruction
id_rs1  in  REG_ADDR_W  source register 1 of the decode instruction
id_rs2  in  REG_ADDR_W  source register 2 of the decode instruction
id_rd  in  REG_ADDR_W  destination register of the decode instruction
id_we  in  1  decode instruction writes rd
id_is_load  in  1  decode instruction is a load (result available only at MEM/WB)
stall  in  1  external freeze (e.g. memory wait)
flush  in  1  kill the decode instruction (branch/jump redirect)
ex_rs1_sel  out  SEL_W  registered mux select for EX operand A
ex_rs2_sel  out  SEL_W  registered mux select for EX operand B
ex_valid  out  1  EX stage holds a real instruction
hazard_stall  out  1  combinational load-use stall request to fetch/decode

Behaviour:
- Reset (asynchronous, active-high): all internal stage registers and all registered outputs go to 0 immediately; hazard_stall reads 0 while rst=1.
- Internal state: EX entry {valid, rd, we, load} and MEM entry {valid, rd, we, load}.
- Instructions leaving MEM are written to the regfile at that edge; regfile reads in ID therefore see them.
- Select computation (combinational, per source rs):
  - rs == 0 -> 0
  - else if EX.valid & EX.we & EX.rd == rs -> 1
  - else if MEM.valid & MEM.we & MEM.rd == rs -> 2
  - else -> 0
  - The younger producer wins when both match.
- hazard_stall = id_valid & EX.valid & EX.load & EX.we & EX.rd != 0 & (EX.rd == id_rs1 | EX.rd == id_rs2). It is purely combinational from current state and inputs.
- Per-edge update, in priority order:
  1. stall=1: hold every register, including sels; flush is ignored this cycle, and upstream must hold flush until stall drops.
  2. flush=1: EX <- bubble (valid=0, sels=0), MEM <- EX.
  3. hazard_stall=1: EX <- bubble (sels=0), MEM <- EX; upstream holds ID. On the next cycle the load sits in MEM and the retried instruction gets sel 2.
  4. Otherwise: EX <- ID entry (valid = id_valid), MEM <- EX, ex_rs*_sel <- computed selects (forced to 0 if id_valid=0).
- Bubbles carry we=0, so they never cause forwarding.
- Latency: select codes appear on ex_rs*_sel exactly one cycle after the instruction is presented in ID (absent stall/hazard).
- Reset mid-operation: state is cleared immediately; the first post-reset instruction sees select 0 for all sources.

Decomposition:
- Shared package fwd_pkg holds:
  - SEL_REGFILE = 2'd0, SEL_EXMEM = 2'd1, SEL_MEMWB = 2'd2
  - REG_ADDR_W
  - stage-entry struct/field widths {valid, rd, we, load}
- One natural sub-module: fwd_stage_reg, a per-stage metadata register with async reset, hold, and bubble-insert controls. It is instantiated twice (EX, MEM).
- Select logic and hazard logic stay in the top module.

Test Plan:
1. Back-to-back dependency: cycle0 ID {rd=5, we=1}; cycle1 ID {rs1=5, rs2=6} -> cycle2 ex_rs1_sel=1, ex_rs2_sel=0.
2. Distance-2 dependency plus younger priority:
   - Instrs {rd=7}, {rd=8}, {rs1=7, rs2=8} -> ex_rs1_sel=2, ex_rs2_sel=1.
   - Instrs {rd=7}, {rd=7}, {rs1=7} -> ex_rs1_sel=1.
3. Load-use: ID {load, rd=3}, then ID {rs2=3}:
   - hazard_stall=1 for one cycle; EX gets a bubble (ex_valid=0, sels=0).
   - Next cycle hazard_stall=0; the following edge gives ex_rs2_sel=2.
4. x0 and non-writers: {rd=0, we=1} then {rs1=0} -> sel 0. {rd=4, we=0} then {rs1=4} -> sel 0.
5. Stall/flush:
   - stall=1 for 3 cycles with flush=1 -> all outputs frozen.
   - stall drops with flush=1 -> ex_valid=0, sels=0, while a MEM-stage rd=9 still forwards sel 2 to the next {rs1=9}.
6. Async reset: assert rst mid-cycle with ex_rs1_sel=1 -> all outputs 0 before the next clk edge; after release, {rs1=5} with no producers -> sel 0.
